// File: rtl/hd_encoder_tx_if.sv
// Message-in / codeword-out handshake bundle for the SECDED transmit framer.
// The slave modport is the encoder's view; the master modport is the view of the block that drives it.
interface hd_encoder_tx_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MSG_WIDTH  = 11
);
  logic                  in_sop;
  logic                  in_eop;
  logic                  in_vld;
  logic [MSG_WIDTH-1:0]  in_data;
  logic                  in_rdy;
  logic                  wr_sop;
  logic                  wr_eop;
  logic                  wr_vld;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  resend;

  modport master (
    output in_sop, in_eop, in_vld, in_data, resend,
    input  in_rdy, wr_sop, wr_eop, wr_vld, wr_data
  );

  modport slave (
    input  in_sop, in_eop, in_vld, in_data, resend,
    output in_rdy, wr_sop, wr_eop, wr_vld, wr_data
  );
endinterface

// File: rtl/hd_encoder_tx.sv
// Hamming SECDED(16,11) transmit encoder and packet framer with whole-packet replay on resend.
// Define HD_ERR_INJ_EN to add inj_mode/inj_pos error injection on word 0 of the first attempt.
module hd_encoder_tx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MSG_WIDTH  = 11,
  parameter int unsigned MAX_WORDS  = 64,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hd_encoder_tx_if.slave       bus,
`ifdef HD_ERR_INJ_EN
  input  logic [1:0]           inj_mode,
  input  logic [3:0]           inj_pos,
`endif
  output logic                 pkt_done,
  output logic                 pkt_drop,
  output logic                 trunc
);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam logic [ADDR_W:0] CntFull = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] CntOne  = (ADDR_W + 1)'(1);
  localparam logic [RW-1:0]   RetryMax = RW'(MAX_RETRY);
  localparam logic [RW-1:0]   RetryOne = RW'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StSop, StSend, StEop} state_e;

  function automatic logic [DATA_WIDTH-1:0] encode(input logic [MSG_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] c;
    c = '0;
    {c[15], c[14], c[13], c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]} = m;
    c[1] = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
    c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
    c[4] = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[8] = ^c[15:9];
    c[0] = ^c[15:1];
    return c;
  endfunction

  state_e                state_q;
  logic [ADDR_W:0]       count_q;
  logic [ADDR_W:0]       ptr_q;
  logic [RW-1:0]         retry_q;
  logic                  resend_seen_q;
  logic                  in_rdy_q, wr_sop_q, wr_eop_q, wr_vld_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  pkt_done_q, pkt_drop_q, trunc_q;

  logic [MSG_WIDTH-1:0]  mem [MAX_WORDS];
  logic                  buf_we;
  logic [ADDR_W-1:0]     buf_waddr;
  logic [DATA_WIDTH-1:0] rd_code;
  logic [DATA_WIDTH-1:0] inj_mask;
  logic                  bad;

  assign rd_code = encode(mem[ptr_q[ADDR_W-1:0]]);
  assign bad     = resend_seen_q | bus.resend;

`ifdef HD_ERR_INJ_EN
  // Only evaluated on the SOP->SEND edge; replays (retry_q != 0) stay clean.
  always_comb begin
    inj_mask = '0;
    if (retry_q == '0) begin
      case (inj_mode)
        2'd1: inj_mask[inj_pos] = 1'b1;
        2'd2: begin
          inj_mask[inj_pos]         = 1'b1;
          inj_mask[inj_pos ^ 4'd1]  = 1'b1;
        end
        default: inj_mask = '0;
      endcase
    end
  end
`else
  assign inj_mask = '0;
`endif

  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = '0;
    if (bus.in_vld) begin
      if ((state_q == StIdle || state_q == StLoad) && bus.in_sop) begin
        buf_we = 1'b1;
      end else if (state_q == StLoad && count_q < CntFull) begin
        buf_we    = 1'b1;
        buf_waddr = count_q[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) mem[buf_waddr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      count_q       <= '0;
      ptr_q         <= '0;
      retry_q       <= '0;
      resend_seen_q <= 1'b0;
      in_rdy_q      <= 1'b1;
      wr_sop_q      <= 1'b0;
      wr_eop_q      <= 1'b0;
      wr_vld_q      <= 1'b0;
      wr_data_q     <= '0;
      pkt_done_q    <= 1'b0;
      pkt_drop_q    <= 1'b0;
      trunc_q       <= 1'b0;
    end else begin
      wr_sop_q   <= 1'b0;
      wr_eop_q   <= 1'b0;
      wr_vld_q   <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_drop_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_vld && bus.in_sop) begin
            count_q <= CntOne;
            trunc_q <= 1'b0;
            if (bus.in_eop) begin
              state_q  <= StSop;
              wr_sop_q <= 1'b1;
              in_rdy_q <= 1'b0;
              ptr_q    <= '0;
            end else begin
              state_q  <= StLoad;
            end
          end
        end
        StLoad: begin
          if (bus.in_vld) begin
            if (bus.in_sop) begin
              count_q <= CntOne;
              trunc_q <= 1'b0;
            end else if (count_q < CntFull) begin
              count_q <= count_q + CntOne;
            end else begin
              trunc_q <= 1'b1;
            end
            if (bus.in_eop) begin
              state_q  <= StSop;
              wr_sop_q <= 1'b1;
              in_rdy_q <= 1'b0;
              ptr_q    <= '0;
            end
          end
        end
        StSop: begin
          state_q       <= StSend;
          wr_vld_q      <= 1'b1;
          wr_data_q     <= rd_code ^ inj_mask;
          ptr_q         <= CntOne;
          resend_seen_q <= 1'b0;
        end
        StSend: begin
          if (bus.resend) resend_seen_q <= 1'b1;
          if (ptr_q == count_q) begin
            state_q  <= StEop;
            wr_eop_q <= 1'b1;
          end else begin
            wr_vld_q  <= 1'b1;
            wr_data_q <= rd_code;
            ptr_q     <= ptr_q + CntOne;
          end
        end
        StEop: begin
          if (bad && retry_q < RetryMax) begin
            retry_q  <= retry_q + RetryOne;
            state_q  <= StSop;
            wr_sop_q <= 1'b1;
            ptr_q    <= '0;
          end else begin
            pkt_drop_q <= bad;
            pkt_done_q <= ~bad;
            state_q    <= StIdle;
            in_rdy_q   <= 1'b1;
            retry_q    <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_rdy  = in_rdy_q;
  assign bus.wr_sop  = wr_sop_q;
  assign bus.wr_eop  = wr_eop_q;
  assign bus.wr_vld  = wr_vld_q;
  assign bus.wr_data = wr_data_q;
  assign pkt_done    = pkt_done_q;
  assign pkt_drop    = pkt_drop_q;
  assign trunc       = trunc_q;
endmodule

// File: tb/tb_hd_encoder_tx.sv
// Scoreboard bench for hd_encoder_tx: stimulus pushes expected output events, a monitor pops them.
module tb_hd_encoder_tx;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hd_encoder_tx_if bus ();
  logic pkt_done, pkt_drop, trunc;
`ifdef HD_ERR_INJ_EN
  logic [1:0] inj_mode;
  logic [3:0] inj_pos;
  assign inj_mode = 2'd0;
  assign inj_pos  = 4'd0;
`endif

  hd_encoder_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
`ifdef HD_ERR_INJ_EN
    .inj_mode (inj_mode),
    .inj_pos  (inj_pos),
`endif
    .pkt_done (pkt_done),
    .pkt_drop (pkt_drop),
    .trunc    (trunc)
  );

  // Hand-computed SECDED(16,11) codewords.
  logic [10:0] msg_tbl  [7] = '{11'h000, 11'h7FF, 11'h001, 11'h002, 11'h400, 11'h555, 11'h2AA};
  logic [15:0] code_tbl [7] = '{16'h0000, 16'hFFFF, 16'h000F, 16'h0033, 16'h8117, 16'hAA5A,
                                16'h55A5};

  // Event layout: {sop, vld, eop, done, drop, data}
  localparam logic [4:0] ESop = 5'b10000, EVld = 5'b01000, EEop = 5'b00100,
                         EDone = 5'b00010, EDrop = 5'b00001;
  logic [20:0] exp_q [$];
  int checks = 0;
  int fails  = 0;
  int stray  = 0;
  bit mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [20:0] obs;
    logic [20:0] e;
    bit in_pkt = 1'b0;
    bit after_eop = 1'b0;
    forever begin
      @(negedge clk);
      obs = {bus.wr_sop, bus.wr_vld, bus.wr_eop, pkt_done, pkt_drop,
             bus.wr_vld ? bus.wr_data : 16'h0000};
      if (!mon_en) begin
        in_pkt = 1'b0;
        after_eop = 1'b0;
        if (pkt_done || pkt_drop) stray++;
      end else begin
        if (in_pkt || after_eop) check("no_gap", {31'd0, obs[20:16] != 5'd0}, 32'd1);
        if (obs[20:16] != 5'd0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", {11'd0, obs}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("event", {11'd0, obs}, {11'd0, e});
          end
          if (obs[20] | obs[19] | obs[18]) check("in_rdy_busy", {31'd0, bus.in_rdy}, 32'd0);
          if (obs[17] | obs[16]) check("in_rdy_idle", {31'd0, bus.in_rdy}, 32'd1);
        end
        after_eop = obs[18];
        if (obs[20]) in_pkt = 1'b1;
        if (obs[18]) in_pkt = 1'b0;
      end
    end
  endtask

  task automatic expect_pkt(input int n, input int start, input int tx, input bit drop);
    int m;
    m = (n > 64) ? 64 : n;
    for (int t = 0; t < tx; t++) begin
      exp_q.push_back({ESop, 16'h0});
      for (int i = 0; i < m; i++) exp_q.push_back({EVld, code_tbl[(start + i) % 7]});
      exp_q.push_back({EEop, 16'h0});
    end
    exp_q.push_back({drop ? EDrop : EDone, 16'h0});
  endtask

  // Called at posedge+1; returns at posedge+1 after the eop beat was accepted.
  task automatic load_pkt(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      bus.in_vld  = 1'b1;
      bus.in_sop  = (i == 0);
      bus.in_eop  = (i == n - 1);
      bus.in_data = msg_tbl[(start + i) % 7];
      @(posedge clk); #1;
    end
    bus.in_vld = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((exp_q.size() != 0 || !bus.in_rdy) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_timeout", {31'd0, cyc >= 1000}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input int k);
    int seen = 0;
    int cyc = 0;
    while (seen < k && cyc < 200) begin
      @(negedge clk);
      if (bus.wr_vld) seen++;
      cyc++;
    end
    check("wait_vld_timeout", {31'd0, seen < k}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_vld = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_data = '0;
    bus.resend = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
    check("rst_outs", {12'd0, bus.wr_sop, bus.wr_eop, bus.wr_vld, bus.wr_data, pkt_done, pkt_drop,
                       trunc}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fork
      monitor();
    join_none

    // 1-word packet, sop+eop on one beat
    expect_pkt(1, 2, 1, 1'b0);
    load_pkt(1, 2);
    check("sop_latency_1w", {31'd0, bus.wr_sop}, 32'd1);
    wait_idle();

    // 3-word packet 000, 7FF, 001
    expect_pkt(3, 0, 1, 1'b0);
    load_pkt(3, 0);
    check("sop_latency_3w", {31'd0, bus.wr_sop}, 32'd1);
    wait_idle();

    // resend pulse during the second word of a 4-word packet -> one replay
    expect_pkt(4, 3, 2, 1'b0);
    load_pkt(4, 3);
    wait_vld(2);
    bus.resend = 1'b1;
    @(posedge clk); #1;
    bus.resend = 1'b0;
    wait_idle();

    // resend held on every attempt -> 4 transmissions then drop
    expect_pkt(2, 1, 4, 1'b1);
    load_pkt(2, 1);
    bus.resend = 1'b1;
    wait_idle();
    bus.resend = 1'b0;

    // 70-word packet truncated to 64; next sop clears trunc
    expect_pkt(70, 0, 1, 1'b0);
    load_pkt(70, 0);
    wait_idle();
    check("trunc_set", {31'd0, trunc}, 32'd1);
    expect_pkt(1, 4, 1, 1'b0);
    load_pkt(1, 4);
    check("trunc_clear", {31'd0, trunc}, 32'd0);
    wait_idle();

    // async reset while word 5 of an 8-word packet is on the output
    mon_en = 1'b0;
    stray = 0;
    load_pkt(8, 0);
    wait_vld(6);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_outs", {12'd0, bus.wr_sop, bus.wr_eop, bus.wr_vld, bus.wr_data, pkt_done,
                             pkt_drop, trunc}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
    check("no_pulse_after_rst", stray, 32'd0);
    mon_en = 1'b1;

    // a fresh packet after reset
    expect_pkt(5, 2, 1, 1'b0);
    load_pkt(5, 2);
    check("sop_latency_post_rst", {31'd0, bus.wr_sop}, 32'd1);
    wait_idle();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/hd_encoder_tx.md
Name: hd_encoder_tx

Overview:
Transmit-side Hamming SECDED encoder and packet framer. It sits directly upstream of the receive-side Hamming decoder/queue stage. It buffers one packet of 11-bit message words and encodes each word into a 16-bit codeword. It emits the packet on the wr_sop/wr_vld/wr_data/wr_eop framing that the decoder consumes, and replays the whole packet when the decoder flags an uncorrectable error.

Parameters:
DATA_WIDTH, 16, codeword width (fixed SECDED(16,11) layout)
MSG_WIDTH, 11, message bits per codeword
MAX_WORDS, 64, buffer depth in words (64 x 16 = 1024-bit decoder queue)
ADDR_W, 6, buffer address width (log2 MAX_WORDS)
MAX_RETRY, 3, replays allowed before the packet is dropped

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_sop  in  1  first message word of packet, qualified by in_vld
in_eop  in  1  last message word of packet, qualified by in_vld
in_vld  in  1  in_data valid
in_data  in  MSG_WIDTH  message word
in_rdy  out  1  block accepts input (high only in IDLE/LOAD)
wr_sop  out  1  one-cycle packet-start marker, no data
wr_eop  out  1  one-cycle packet-end marker, no data
wr_vld  out  1  wr_data valid
wr_data  out  DATA_WIDTH  encoded codeword
resend  in  1  decoder error, two-bit error detected; replay request
pkt_done  out  1  one-cycle pulse: packet sent without a resend request
pkt_drop  out  1  one-cycle pulse: packet abandoned after MAX_RETRY replays
trunc  out  1  sticky per packet: words beyond MAX_WORDS were discarded; cleared at next in_sop

Behaviour:
- Reset: all outputs 0 except in_rdy, which is 1 after reset (IDLE); state IDLE; word count, retry count, read pointer all 0.
- Encoding (combinational on the buffer read, registered on output):
  - Message bits m[0..10] go to codeword bits 3,5,6,7,9,10,11,12,13,14,15.
  - Codeword bit1 = XOR of bits 3,5,7,9,11,13,15.
  - Bit2 = XOR of bits 3,6,7,10,11,14,15.
  - Bit4 = XOR of bits 5,6,7,12,13,14,15.
  - Bit8 = XOR of bits 9..15.
  - Bit0 = XOR of bits 1..15 (overall parity).
- FSM IDLE -> LOAD -> SOP -> SEND -> EOP -> (SOP | IDLE).
  - IDLE: in_vld & in_sop writes word 0, count=1. If in_eop is high on the same beat, go to SOP (1-word packet); otherwise go to LOAD. in_vld without in_sop is ignored.
  - LOAD: each in_vld beat writes buf[count] and increments count. Beats with count==MAX_WORDS are discarded and set trunc. in_vld & in_eop ends the load and goes to SOP. in_vld & in_sop restarts the packet: the beat becomes word 0, count=1, trunc cleared.
  - SOP: wr_sop=1 for exactly one cycle, wr_vld=0; read pointer=0; clear resend_seen.
  - SEND: wr_vld=1, wr_data=encode(buf[ptr]), one word per cycle, no gaps. After word count-1, go to EOP.
  - EOP: wr_eop=1 for one cycle, wr_vld=0.
    - If resend_seen (or resend high this cycle) and retry<MAX_RETRY: retry++, go to SOP.
    - If resend_seen and retry==MAX_RETRY: pulse pkt_drop, go to IDLE.
    - Otherwise: pulse pkt_done, go to IDLE.
    - Retry count clears when entering IDLE.
- resend is sampled in SEND and EOP only and latched into resend_seen. It is ignored in other states.
- Latency: wr_sop is high on the cycle after the in_eop beat is accepted. A packet of N words occupies N+2 output cycles.
- Outputs are all registered; wr_sop, wr_vld and wr_eop are mutually exclusive.
- in_rdy=0 from SOP until return to IDLE; no back-to-back overlap of load and send.
- Asynchronous reset mid-packet: abandon the packet immediately, outputs go to reset values, no pkt_done/pkt_drop pulse.

Optional Feature:
HD_ERR_INJ_EN:
- When defined, adds inputs inj_mode[1:0] and inj_pos[3:0], sampled at SOP of the first attempt only.
  - inj_mode=1 flips codeword bit inj_pos of word 0.
  - inj_mode=2 flips bits inj_pos and inj_pos^1 of word 0.
  - inj_mode=0 or 3 makes no change.
  - Replays are always sent clean.
- When undefined, the ports are absent and wr_data is always the clean encoding.

Test Plan:
- 1-word packet, in_data=11'h001 (sop+eop same beat) -> wr_sop, then wr_vld with wr_data=16'h000F, then wr_eop; pkt_done pulse one cycle after wr_eop; 3 output cycles total.
- 3-word packet 11'h000, 11'h7FF, 11'h001 -> wr_data 16'h0000, 16'hFFFF, 16'h000F on consecutive cycles; in_rdy low from SOP through EOP.
- resend pulsed during word 2 of a 4-word packet -> identical full replay (SOP, 4 words, EOP) immediately after the first EOP; then pkt_done.
- resend asserted on every attempt -> 1+MAX_RETRY=4 transmissions, then pkt_drop pulse and no pkt_done.
- 70-word input packet -> 64 words sent, trunc=1; the next packet's in_sop clears trunc.
- rst_n low during SEND word 5 -> all outputs 0 asynchronously, in_rdy=1 after release, no pulses; a new packet is then accepted normally.
